// File: rtl/serial_bus_arbiter_if.sv
// rtl/serial_bus_arbiter_if.sv - serial bus request/grant/split signal bundle
// master: arbiter side (drives grants); slave: requester side (drives requests).
interface serial_bus_arbiter_if #(
    parameter int MASTER_NO = 2
);
    logic [MASTER_NO-1:0] bus_req;
    logic [MASTER_NO-1:0] bus_util;
    logic [MASTER_NO-1:0] split_on;
    logic [MASTER_NO-1:0] bus_grant;
    logic [MASTER_NO-1:0] split_en;
    logic [2:0]           owner_id;
    logic                 bus_busy;
    logic [MASTER_NO-1:0] split_pending;

    modport master (
        input  bus_req, bus_util, split_on,
        output bus_grant, split_en, owner_id, bus_busy, split_pending
    );

    modport slave (
        output bus_req, bus_util, split_on,
        input  bus_grant, split_en, owner_id, bus_busy, split_pending
    );
endinterface

// File: rtl/serial_bus_arbiter.sv
// rtl/serial_bus_arbiter.sv - fixed-priority serial bus arbiter with split pre-emption
// Master 0 has highest priority; a lower-priority owner may be split off and re-granted later.
module serial_bus_arbiter #(
    parameter int MASTER_NO     = 2,
    parameter int GRANT_TIMEOUT = 8,
    parameter int SPLIT_ENABLE  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_bus_arbiter_if.master   bus
);
    localparam int IDW = (MASTER_NO > 1) ? $clog2(MASTER_NO) : 1;
    localparam int TW  = $clog2(GRANT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        BUSY    = 3'd2,
        SPLIT   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [MASTER_NO-1:0] grant_q, grant_d;
    logic [MASTER_NO-1:0] split_en_q, split_en_d;
    logic [MASTER_NO-1:0] pend_q, pend_d;
    logic [IDW-1:0]       owner_q, owner_d;
    logic [TW-1:0]        tmo_q, tmo_d;

    logic [IDW-1:0]       cand;
    logic                 cand_valid;
    logic [MASTER_NO-1:0] below_mask;
    logic                 higher_req;

    // Lowest-index requester wins; scan downwards so the last hit is the lowest.
    always_comb begin
        cand       = '0;
        cand_valid = 1'b0;
        for (int i = MASTER_NO - 1; i >= 0; i--) begin
            if (bus.bus_req[i]) begin
                cand       = IDW'(i);
                cand_valid = 1'b1;
            end
        end
    end

    always_comb begin
        below_mask = '0;
        for (int i = 0; i < MASTER_NO; i++) begin
            below_mask[i] = (IDW'(i) < owner_q);
        end
        higher_req = |(bus.bus_req & below_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            split_en_q <= '0;
            pend_q     <= '0;
            owner_q    <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            split_en_q <= split_en_d;
            pend_q     <= pend_d;
            owner_q    <= owner_d;
            tmo_q      <= tmo_d;
        end
    end

    // Grant and owner are dropped on entry to RELEASE so that cycle carries no grant.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        split_en_d = '0;
        pend_d     = pend_q;
        owner_d    = owner_q;
        tmo_d      = tmo_q;
        case (state_q)
            IDLE: begin
                if (cand_valid) begin
                    owner_d       = cand;
                    grant_d       = '0;
                    grant_d[cand] = 1'b1;
                    tmo_d         = '0;
                    pend_d[cand]  = 1'b0;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (bus.bus_util[owner_q]) begin
                    state_d = BUSY;
                end else if (!bus.bus_req[owner_q] || tmo_q == TW'(GRANT_TIMEOUT - 1)) begin
                    grant_d = '0;
                    owner_d = '0;
                    state_d = RELEASE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            BUSY: begin
                if (!bus.bus_util[owner_q]) begin
                    grant_d = '0;
                    owner_d = '0;
                    state_d = RELEASE;
                end else if (SPLIT_ENABLE != 0 && higher_req) begin
                    split_en_d[owner_q] = 1'b1;
                    state_d             = SPLIT;
                end
            end
            SPLIT: begin
                if (bus.split_on[owner_q] || !bus.bus_util[owner_q]) begin
                    if (bus.split_on[owner_q]) begin
                        pend_d[owner_q] = 1'b1;
                    end
                    grant_d = '0;
                    owner_d = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                grant_d = '0;
                owner_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                owner_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.bus_grant     = grant_q;
    assign bus.split_en      = split_en_q;
    assign bus.split_pending = pend_q;
    assign bus.owner_id      = 3'(owner_q);
    assign bus.bus_busy      = (state_q == GRANT) || (state_q == BUSY) || (state_q == SPLIT);
endmodule

// File: doc/serial_bus_arbiter.md
Name: serial_bus_arbiter

Overview:
- Central arbiter for the serial bus. It shares the single address/data/burst serial lanes among MASTER_NO master_out_port instances.
- Fixed priority: master 0 is highest.
- Grants the bus on bus_req, tracks ownership via bus_util, and pre-empts a low-priority owner through split_en when a higher-priority master requests.
- Records split masters and returns the bus to them later.

Parameters:
- MASTER_NO, 2, number of masters; legal range 2..8.
- GRANT_TIMEOUT, 8, cycles the arbiter waits in GRANT for bus_util before revoking the grant.
- SPLIT_ENABLE, 1, 1 allows pre-emption; 0 never asserts split_en.

Ports:
- clk  in  1  bus clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus_req  in  MASTER_NO  per-master bus request, level.
- bus_util  in  MASTER_NO  per-master "bus in use", level; asserted by the owner from the cycle after it samples its grant.
- split_on  in  MASTER_NO  per-master acknowledgement that it abandoned its transfer after split_en.
- bus_grant  out  MASTER_NO  one-hot or zero grant, registered.
- split_en  out  MASTER_NO  per-master split command, registered, one-hot or zero.
- owner_id  out  3  index of the current grantee; 0 when no grant is held.
- bus_busy  out  1  high in GRANT, BUSY and SPLIT.
- split_pending  out  MASTER_NO  masters split off and not yet re-granted.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, owner register 0. Reset is honoured mid-transfer with no handshake.
- States: IDLE, GRANT, BUSY, SPLIT, RELEASE.
- IDLE:
  - Candidate = lowest-index i with bus_req[i]=1.
  - If a candidate exists: owner<=i, bus_grant[i]<=1, timeout<=0, go to GRANT. Grant is visible 1 cycle after bus_req is sampled.
  - If the candidate has split_pending[i]=1, clear that bit on the same edge.
- GRANT:
  - bus_util[owner]=1 -> BUSY.
  - Otherwise, bus_req[owner]=0 or timeout=GRANT_TIMEOUT-1 -> RELEASE.
  - Otherwise timeout<=timeout+1.
  - bus_util from a non-owner is ignored.
- BUSY:
  - bus_util[owner]=0 -> RELEASE; completion takes priority over pre-emption in the same cycle.
  - Otherwise, if SPLIT_ENABLE=1 and some j<owner has bus_req[j]=1: split_en[owner]<=1, go to SPLIT.
- SPLIT:
  - split_en is a single-cycle pulse; it is cleared on entry.
  - Wait for split_on[owner]=1 or bus_util[owner]=0.
  - If split_on was seen: split_pending[owner]<=1.
  - In both cases go to RELEASE. A master that completes instead of splitting is not marked pending.
  - No timeout in SPLIT.
- RELEASE:
  - bus_grant<=0, owner_id<=0, go to IDLE.
  - Guarantees at least 1 cycle with no grant between owners; bus_busy is 0 in this cycle.
- Grant invariant: at most one bus_grant bit high at any time, and it changes only in IDLE->GRANT and RELEASE.
- Re-grant of split masters:
  - A split master re-requests (bus_req) from its IDLE.
  - It is granted by normal priority.
  - A pending master with a lower index than the requester still wins.
- Simultaneous events in IDLE: several requests -> lowest index wins; the others keep waiting with no starvation protection beyond pre-emption.
- Owner dropping bus_req while in BUSY has no effect; only bus_util ends ownership.
- owner_id uses only the low $clog2(MASTER_NO) bits; the upper bits are tied 0.

Test Plan:
- Single request: bus_req=2'b10 at cycle 0 -> bus_grant=2'b10 and owner_id=1 at cycle 1. bus_util[1]=1 at cycle 2 -> BUSY. bus_util low at cycle 10 -> bus_grant=0 at cycle 11, IDLE at cycle 12.
- Simultaneous requests: bus_req=2'b11 in IDLE -> bus_grant=2'b01. After master 0 drops bus_util: RELEASE, then master 1 is granted on the second cycle after.
- Pre-emption: master 1 in BUSY, bus_req[0] rises -> split_en=2'b10 for exactly 1 cycle. split_on[1]=1 two cycles later -> split_pending=2'b10, then grant 2'b01. When master 0 finishes and master 1 re-requests -> grant 2'b10 and split_pending=0.
- Timeout: grant to master 1 with bus_util held 0 -> grant revoked after 8 cycles in GRANT, then a RELEASE cycle, then re-grant if bus_req[1] is still high.
- Same-cycle race: in BUSY, bus_util[owner] falls in the same cycle bus_req[0] rises -> no split_en pulse, RELEASE, then master 0 granted.
- Reset mid-BUSY: assert rst -> bus_grant, split_en and split_pending = 0 immediately, without waiting for a clock edge. With SPLIT_ENABLE=0, a higher-priority request in BUSY never produces split_en.
